// File: rtl/red_pitaya_sort_pulser.sv
// FADS sort pulser: turns a sort trigger into a bipolar square-wave burst on the DAC.
// Optional: define SORT_PULSER_RETRIGGER_EN so that triggers during BURST/HOLDOFF restart the burst.
module red_pitaya_sort_pulser #(
  parameter int DWD = 14,
  parameter int MEM = 32
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rstn_i,
  input  logic                  sort_trig_i,
  output logic signed [DWD-1:0] dac_o,
  output logic                  pulse_active_o,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic [3:0]            sys_sel,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack
);

`ifdef SORT_PULSER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam logic [19:0] A_AMP    = 20'h00;
  localparam logic [19:0] A_HP     = 20'h04;
  localparam logic [19:0] A_NHALF  = 20'h08;
  localparam logic [19:0] A_HOLD   = 20'h0C;
  localparam logic [19:0] A_CTRL   = 20'h10;
  localparam logic [19:0] A_BURSTS = 20'h20;
  localparam logic [19:0] A_MISSED = 20'h24;
  localparam logic [19:0] A_STATUS = 20'h28;
  localparam logic [31:0] AMP_MAX  = 32'((2 ** (DWD - 1)) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, HOLDOFF = 2'd2} state_t;

  function automatic logic [DWD-2:0] sat_amp(input logic [31:0] w);
    return (w > AMP_MAX) ? AMP_MAX[DWD-2:0] : w[DWD-2:0];
  endfunction

  function automatic logic signed [DWD-1:0] level(input logic [DWD-2:0] mag, input logic neg);
    logic signed [DWD-1:0] p;
    p = signed'({1'b0, mag});
    return neg ? -p : p;
  endfunction

  logic [DWD-2:0] amplitude;
  logic [15:0]    half_period, n_half, hp_eff, hp_sh, phase_cnt, half_cnt;
  logic [MEM-1:0] holdoff, hold_cnt, bursts, missed;
  logic           enable, polarity, trig_q;
  state_t         state;

  logic unused_bus;
  assign unused_bus = &{1'b0, sys_sel};

  wire  trig_rise = sort_trig_i & ~trig_q;
  wire  start_ok  = trig_rise & enable & (n_half != 16'd0);
  wire  soft_rst  = sys_wen & (sys_addr[19:0] == A_CTRL) & sys_wdata[2];
  assign hp_eff   = (half_period == 16'd0) ? 16'd1 : half_period;
  assign sys_err  = 1'b0;

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      amplitude   <= (DWD-1)'(4000);
      half_period <= 16'd1250;
      n_half      <= 16'd100;
      holdoff     <= '0;
      enable      <= 1'b1;
      polarity    <= 1'b0;
    end else if (sys_wen) begin
      case (sys_addr[19:0])
        A_AMP:   amplitude   <= sat_amp(sys_wdata);
        A_HP:    half_period <= sys_wdata[15:0];
        A_NHALF: n_half      <= sys_wdata[15:0];
        A_HOLD:  holdoff     <= MEM'(sys_wdata);
        A_CTRL:  begin
          enable   <= sys_wdata[0];
          polarity <= sys_wdata[1];
        end
        default: ;
      endcase
    end
  end

  // Burst sequencer; the burst runs from hp_sh/half_cnt so live writes wait for the next start
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      state          <= IDLE;
      dac_o          <= '0;
      pulse_active_o <= 1'b0;
      trig_q         <= 1'b0;
      bursts         <= '0;
      missed         <= '0;
    end else begin
      trig_q <= sort_trig_i;
      if (soft_rst || (!enable && state != IDLE)) begin
        state          <= IDLE;
        dac_o          <= '0;
        pulse_active_o <= 1'b0;
        if (soft_rst) begin
          bursts <= '0;
          missed <= '0;
        end
      end else if (start_ok && (state == IDLE || RETRIG)) begin
        hp_sh          <= hp_eff;
        phase_cnt      <= hp_eff - 16'd1;
        half_cnt       <= n_half;
        dac_o          <= level(amplitude, polarity);
        pulse_active_o <= 1'b1;
        bursts         <= bursts + MEM'(1);
        state          <= BURST;
      end else begin
        if (trig_rise && state != IDLE && !RETRIG) missed <= missed + MEM'(1);
        case (state)
          BURST: begin
            if (phase_cnt == 16'd0) begin
              if (half_cnt == 16'd1) begin
                dac_o          <= '0;
                pulse_active_o <= 1'b0;
                if (holdoff != '0) begin
                  state    <= HOLDOFF;
                  hold_cnt <= holdoff - MEM'(1);
                end else begin
                  state <= IDLE;
                end
              end else begin
                dac_o     <= -dac_o;
                half_cnt  <= half_cnt - 16'd1;
                phase_cnt <= hp_sh - 16'd1;
              end
            end else begin
              phase_cnt <= phase_cnt - 16'd1;
            end
          end
          HOLDOFF: begin
            if (hold_cnt == '0) state <= IDLE;
            else                hold_cnt <= hold_cnt - MEM'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) begin
        case (sys_addr[19:0])
          A_AMP:    sys_rdata <= 32'(amplitude);
          A_HP:     sys_rdata <= 32'(half_period);
          A_NHALF:  sys_rdata <= 32'(n_half);
          A_HOLD:   sys_rdata <= 32'(holdoff);
          A_CTRL:   sys_rdata <= {29'd0, 1'b0, polarity, enable};
          A_BURSTS: sys_rdata <= 32'(bursts);
          A_MISSED: sys_rdata <= 32'(missed);
          A_STATUS: sys_rdata <= {30'd0, state};
          default:  sys_rdata <= '0;
        endcase
      end
    end
  end

endmodule
